// File: rtl/hv_bs_collector_if.sv
// Capture handshake and result bus between the bit-stream collector and its neighbours.
// The master side issues start and supplies the stream bit; the slave side is the collector.
interface hv_bs_collector_if #(
    parameter int D = 1024
);
    localparam int CW = $clog2(D + 1);

    logic          start;
    logic          bs_in;
    logic          src_reset;
    logic          busy;
    logic          done;
    logic          hv_valid;
    logic [D-1:0]  hv_out;
    logic [CW-1:0] ones_count;

    modport master (
        output start,
        output bs_in,
        input  src_reset,
        input  busy,
        input  done,
        input  hv_valid,
        input  hv_out,
        input  ones_count
    );

    modport slave (
        input  start,
        input  bs_in,
        output src_reset,
        output busy,
        output done,
        output hv_valid,
        output hv_out,
        output ones_count
    );
endinterface

// File: rtl/hv_bs_collector.sv
// Serial-to-parallel collector: restarts the VDC bit-stream generator, captures D stream bits
// into a hypervector while counting ones, then publishes both with a done pulse.
module hv_bs_collector #(
    parameter int D = 1024
) (
    input  logic               clk,
    input  logic               reset,
    hv_bs_collector_if.slave   bus
);
    localparam int CW    = $clog2(D + 1);
    localparam int IDX_W = $clog2(D);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(D - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SYNC    = 2'd1;
    localparam logic [1:0] COLLECT = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [D-1:0]     work_hv;
    logic [CW-1:0]    work_cnt;
    logic [D-1:0]     work_hv_nxt;
    logic [CW-1:0]    work_cnt_nxt;

    logic             src_reset_r;
    logic             busy_r;
    logic             done_r;
    logic             hv_valid_r;
    logic [D-1:0]     hv_out_r;
    logic [CW-1:0]    ones_count_r;

    // Next work state including the bit arriving this cycle, so the final edge publishes it too.
    always_comb begin
        work_hv_nxt      = work_hv;
        work_hv_nxt[idx] = bus.bs_in;
        work_cnt_nxt     = work_cnt + CW'(bus.bs_in);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            work_hv      <= '0;
            work_cnt     <= '0;
            src_reset_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            hv_valid_r   <= 1'b0;
            hv_out_r     <= '0;
            ones_count_r <= '0;
        end else begin
            done_r      <= 1'b0;
            src_reset_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state       <= SYNC;
                        src_reset_r <= 1'b1;
                        busy_r      <= 1'b1;
                        hv_valid_r  <= 1'b0;
                    end
                end
                SYNC: begin
                    // Generator counter is being reset this cycle; it reads 0 in the first COLLECT cycle.
                    state    <= COLLECT;
                    idx      <= '0;
                    work_cnt <= '0;
                end
                COLLECT: begin
                    work_hv  <= work_hv_nxt;
                    work_cnt <= work_cnt_nxt;
                    if (idx == LAST_IDX) begin
                        state        <= DONE;
                        idx          <= '0;
                        busy_r       <= 1'b0;
                        done_r       <= 1'b1;
                        hv_valid_r   <= 1'b1;
                        hv_out_r     <= work_hv_nxt;
                        ones_count_r <= work_cnt_nxt;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.src_reset  = src_reset_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.hv_valid   = hv_valid_r;
    assign bus.hv_out     = hv_out_r;
    assign bus.ones_count = ones_count_r;
endmodule

// File: tb/tb_hv_bs_collector.sv
// Bench for hv_bs_collector: D=1024 and D=16 instances fed by a behavioural 10-bit VDC generator,
// results compared to a reference hypervector computed directly from the scalar.
module tb_hv_bs_collector;
    localparam int DB = 1024;
    localparam int DS = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hv_bs_collector_if #(.D(DB)) bb ();
    hv_bs_collector_if #(.D(DS)) sb ();

    hv_bs_collector #(.D(DB)) dut_b (.clk(clk), .reset(reset), .bus(bb.slave));
    hv_bs_collector #(.D(DS)) dut_s (.clk(clk), .reset(reset), .bus(sb.slave));

    int checks = 0;
    int errs = 0;
    int cyc = 0;
    int src_cnt_b = 0;
    int done_cnt_b = 0;
    int src_cnt_s = 0;
    int prev_cnt_b = 0;
    int scal_b = 0;
    int scal_s = 0;
    logic [9:0] gcnt_b = '0;
    logic [9:0] gcnt_s = '0;

    function automatic logic [9:0] brev(input logic [9:0] c);
        logic [9:0] r;
        for (int j = 0; j < 10; j++) r[j] = c[9-j];
        return r;
    endfunction

    // Unipolar VDC generator: emits 1 when the scalar exceeds the bit-reversed count.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        gcnt_b <= bb.src_reset ? 10'd0 : gcnt_b + 10'd1;
        gcnt_s <= sb.src_reset ? 10'd0 : gcnt_s + 10'd1;
        if (bb.src_reset) src_cnt_b <= src_cnt_b + 1;
        if (bb.done) done_cnt_b <= done_cnt_b + 1;
        if (sb.src_reset) src_cnt_s <= src_cnt_s + 1;
    end
    assign bb.bs_in = (scal_b > int'(brev(gcnt_b)));
    assign sb.bs_in = (scal_s > int'(brev(gcnt_s)));

    function automatic logic [DB-1:0] model_b(input int sc);
        logic [DB-1:0] m;
        for (int i = 0; i < DB; i++) m[i] = (sc > int'(brev(10'(i % 1024))));
        return m;
    endfunction

    function automatic logic [DS-1:0] model_s(input int sc);
        logic [DS-1:0] m;
        for (int i = 0; i < DS; i++) m[i] = (sc > int'(brev(10'(i))));
        return m;
    endfunction

    function automatic int popdiff(input logic [DB-1:0] a, input logic [DB-1:0] b);
        int n = 0;
        for (int i = 0; i < DB; i++) if (a[i] !== b[i]) n++;
        return n;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_done_b(output int t);
        t = -1;
        for (int n = 0; n < DB + 10; n++) begin
            @(negedge clk);
            if (bb.done) begin
                t = cyc + 1;
                break;
            end
        end
        if (t < 0) check("done_timeout_b", 64'd0, 64'd1);
    endtask

    task automatic check_res_b(input string tag, input int sc);
        logic [DB-1:0] e;
        int cnt;
        e = model_b(sc);
        cnt = 0;
        for (int i = 0; i < DB; i++) cnt += int'(e[i]);
        check({tag, "_cnt"}, 64'(bb.ones_count), 64'(cnt));
        check({tag, "_hvdiff"}, 64'(popdiff(bb.hv_out, e)), 64'd0);
        check({tag, "_hvlo"}, bb.hv_out[63:0], e[63:0]);
        check({tag, "_valid"}, 64'(bb.hv_valid), 64'd1);
        check({tag, "_busy"}, 64'(bb.busy), 64'd0);
        prev_cnt_b = cnt;
    endtask

    task automatic run_b(input string tag, input int sc);
        int k, t, s0;
        scal_b = sc;
        s0 = src_cnt_b;
        bb.start = 1'b1;
        @(negedge clk);
        k = cyc;
        bb.start = 1'b0;
        check({tag, "_valid_clr"}, 64'(bb.hv_valid), 64'd0);
        check({tag, "_src_hi"}, 64'(bb.src_reset), 64'd1);
        repeat (100) @(negedge clk);
        check({tag, "_stable"}, 64'(bb.ones_count), 64'(prev_cnt_b));
        wait_done_b(t);
        check({tag, "_latency"}, 64'(t - k), 64'(DB + 2));
        check_res_b(tag, sc);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(bb.done), 64'd0);
        check({tag, "_valid_hold"}, 64'(bb.hv_valid), 64'd1);
        check({tag, "_src_once"}, 64'(src_cnt_b - s0), 64'd1);
    endtask

    task automatic run_s(input string tag, input int sc);
        int k, t;
        scal_s = sc;
        sb.start = 1'b1;
        @(negedge clk);
        k = cyc;
        sb.start = 1'b0;
        t = -1;
        for (int n = 0; n < DS + 10; n++) begin
            @(negedge clk);
            if (sb.done) begin
                t = cyc + 1;
                break;
            end
        end
        if (t < 0) check("done_timeout_s", 64'd0, 64'd1);
        check({tag, "_latency"}, 64'(t - k), 64'(DS + 2));
        check({tag, "_hv"}, 64'(sb.hv_out), 64'(model_s(sc)));
        check({tag, "_cnt"}, 64'(sb.ones_count), 64'($countones(model_s(sc))));
        @(negedge clk);
    endtask

    initial begin
        int k, t, t1, t2, s0;
        bb.start = 1'b0;
        sb.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_busy", 64'(bb.busy), 64'd0);
        check("rst_done", 64'(bb.done), 64'd0);
        check("rst_valid", 64'(bb.hv_valid), 64'd0);
        check("rst_cnt", 64'(bb.ones_count), 64'd0);
        check("rst_hv", 64'(popdiff(bb.hv_out, '0)), 64'd0);
        check("rst_src_never", 64'(src_cnt_b + src_cnt_s), 64'd0);

        run_b("s512", 512);
        check("s512_lit_cnt", 64'(bb.ones_count), 64'd512);
        check("s512_lit_lo", bb.hv_out[63:0], 64'h5555_5555_5555_5555);
        run_b("s0", 0);
        run_b("s1023", 1023);
        check("s1023_top", 64'(bb.hv_out[DB-1]), 64'd0);
        for (int r = 0; r < 3; r++) run_b("rand", int'($urandom_range(0, 1023)));

        // Extra start pulses during COLLECT and DONE must be dropped.
        scal_b = 512;
        s0 = done_cnt_b;
        bb.start = 1'b1;
        @(negedge clk);
        k = cyc;
        bb.start = 1'b0;
        repeat (300) @(negedge clk);
        bb.start = 1'b1;
        @(negedge clk);
        bb.start = 1'b0;
        wait_done_b(t);
        check("ign_latency", 64'(t - k), 64'(DB + 2));
        check_res_b("ign", 512);
        bb.start = 1'b1;
        @(negedge clk);
        bb.start = 1'b0;
        repeat (DB + 10) @(negedge clk);
        check("ign_one_done", 64'(done_cnt_b - s0), 64'd1);
        check("ign_idle", 64'(bb.busy), 64'd0);

        // start held high: back-to-back captures.
        scal_b = 512;
        bb.start = 1'b1;
        wait_done_b(t1);
        check_res_b("held1", 512);
        scal_b = 256;
        wait_done_b(t2);
        bb.start = 1'b0;
        check("held_period", 64'(t2 - t1), 64'(DB + 3));
        check_res_b("held2", 256);
        @(negedge clk);

        // Reset in the middle of a capture at index 500.
        scal_b = 512;
        bb.start = 1'b1;
        @(negedge clk);
        bb.start = 1'b0;
        repeat (501) @(negedge clk);
        check("mid_busy_pre", 64'(bb.busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_busy", 64'(bb.busy), 64'd0);
        check("mid_done", 64'(bb.done), 64'd0);
        check("mid_valid", 64'(bb.hv_valid), 64'd0);
        check("mid_src", 64'(bb.src_reset), 64'd0);
        check("mid_cnt", 64'(bb.ones_count), 64'd0);
        check("mid_hv", 64'(popdiff(bb.hv_out, '0)), 64'd0);
        prev_cnt_b = 0;
        run_b("s768", 768);
        check("s768_lit_cnt", 64'(bb.ones_count), 64'd768);
        check("s768_lit_lo", bb.hv_out[63:0], 64'h7777_7777_7777_7777);

        run_s("d16_512", 512);
        check("d16_lit_hv", 64'(sb.hv_out), 64'h5555);
        check("d16_lit_cnt", 64'(sb.ones_count), 64'd8);
        for (int r = 0; r < 3; r++) run_s("d16_rand", int'($urandom_range(0, 1023)));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
